// File: rtl/sync_multi.sv
// sync_multi: WIDTH-channel asynchronous-input synchronizer with an optional
// per-channel stability filter and registered-history rise/fall pulses.

module sync_multi_lane #(
    parameter int   STAGES     = 2,
    parameter logic RST_BIT    = 1'b0,
    parameter int   FILTER_LEN = 0,
    parameter int   CNT_W      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse,
    output logic fall_pulse
);
    logic [STAGES-1:0] chain;
    logic              s;
    logic              prev;

    // Plain flop chain: only chain[0] touches the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) chain <= {STAGES{RST_BIT}};
        else     chain <= {chain[STAGES-2:0], async_in};
    end

    assign s = chain[STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_nofilt
            assign sync_out = s;
        end else begin : g_filt
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);
            logic [CNT_W-1:0] cnt;
            logic             f;

            // A new level must differ from f for FILTER_LEN straight cycles;
            // any return to f restarts the count.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt <= '0;
                    f   <= RST_BIT;
                end else if (s == f) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    f   <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            assign sync_out = f;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) prev <= RST_BIT;
        else     prev <= sync_out;
    end

    assign rise_pulse = sync_out & ~prev;
    assign fall_pulse = ~sync_out & prev;
endmodule

module sync_multi #(
    parameter int               WIDTH      = 4,
    parameter int               STAGES     = 2,
    parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}},
    parameter int               FILTER_LEN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);
    localparam int CNT_W = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_multi: STAGES must be at least 2");
        end
    endgenerate

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        sync_multi_lane #(
            .STAGES     (STAGES),
            .RST_BIT    (RST_VAL[i]),
            .FILTER_LEN (FILTER_LEN),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .async_in   (async_in[i]),
            .sync_out   (sync_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

    assign any_change = |(rise_pulse | fall_pulse);
endmodule

// File: doc/sync_multi.md
Name: sync_multi

Overview:
Parametrised multi-channel input synchronizer. It is the successor to the fixed two-flop single-bit synchronizer. It carries WIDTH independent asynchronous inputs into the clk domain through a configurable-depth flop chain. It adds an optional per-channel stability (glitch) filter and registered rise/fall edge pulses. It sits at the chip boundary, between pad inputs (buttons, serial lines, handshake strobes) and the core logic.

Parameters:
WIDTH, 4, number of independent channels (>=1)
STAGES, 2, synchronizer flops per channel (>=2; values <2 are a compile-time error)
RST_VAL, {WIDTH{1'b0}}, reset value of every chain stage, sync_out and the edge-history register, per bit
FILTER_LEN, 0, consecutive cycles a new chain-output value must persist before sync_out accepts it; 0 = filter bypassed
CNT_W, $clog2(FILTER_LEN+1) (min 1), filter counter width, derived, not to be overridden

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
async_in  input  WIDTH  asynchronous channel inputs
sync_out  output  WIDTH  synchronized (and optionally filtered) level per channel
rise_pulse  output  WIDTH  one-cycle pulse when the sync_out bit goes 0->1
fall_pulse  output  WIDTH  one-cycle pulse when the sync_out bit goes 1->0
any_change  output  1  OR of rise_pulse|fall_pulse across all channels

Behaviour:
- One clock; reset is synchronous and active-high: rst sampled high at a rising clk edge resets the block at that edge. No asynchronous reset path.
- Reset state:
  - all chain stages, sync_out and the history register (prev) = RST_VAL;
  - filter counters = 0;
  - rise_pulse = fall_pulse = 0; any_change = 0.
  - No edge pulse may be generated by the reset itself or by the first cycles after it.
- Chain: stage[0] <= async_in; stage[k] <= stage[k-1]; s = stage[STAGES-1]. Only stage[0] may sample async_in. No logic between stages.
- FILTER_LEN=0:
  - sync_out = s, a registered chain output.
  - async_in stable before edge N -> sync_out shows the new value after edge N+STAGES-1 (STAGES-edge latency, counting edge N).
- FILTER_LEN=L>0, per channel, with independent counter cnt and filtered register f (sync_out = f):
  - s == f -> cnt <= 0;
  - s != f and cnt < L-1 -> cnt <= cnt+1;
  - s != f and cnt == L-1 -> f <= s, cnt <= 0.
  - A change at s is accepted only after L consecutive differing cycles. Total latency is STAGES+L edges.
  - Any return of s to f before acceptance clears cnt. A glitch shorter than L cycles at s never reaches sync_out.
  - cnt saturates logically at L-1 and never wraps.
- Edges:
  - prev <= sync_out every cycle.
  - rise_pulse = sync_out & ~prev; fall_pulse = ~sync_out & prev. This is combinational from registers and is high for exactly the first cycle sync_out holds the new value.
  - any_change = |(rise_pulse|fall_pulse).
- Channels are fully independent. Simultaneous rise on some bits and fall on others in the same cycle is legal and is reported on both vectors.
- Reset mid-operation: in-flight values in the chain and partial filter counts are discarded. Outputs return to the reset state at that edge, with no pulses.
- Metastability: the functional model treats stage[0] as ideal. Bench stimulus changes async_in away from clk edges.

Test Plan:
- WIDTH=4, STAGES=2, FILTER_LEN=0, RST_VAL=0: reset, then drive async_in=4'b0101 mid-cycle -> sync_out=4'b0101 after 2 rising edges; rise_pulse=4'b0101 and any_change=1 for exactly 1 cycle; fall_pulse=0 throughout.
- STAGES=3: drive 4'b1111 then 4'b0000 -> each sync_out transition lags by 3 edges; fall_pulse=4'b1111 for exactly 1 cycle on the second transition.
- FILTER_LEN=3: hold bit0 high for 2 cycles then low -> sync_out[0] stays 0 and no pulses occur. Then hold bit0 high for 3+ cycles -> sync_out[0]=1 at edge STAGES+3 after the change, with rise_pulse[0]=1 for one cycle.
- RST_VAL=4'b1111, FILTER_LEN=0: release reset with async_in=4'b1111 -> sync_out=4'b1111 and no fall_pulse at any time. Then drive 4'b0110 -> fall_pulse=4'b1001 for one cycle.
- Mixed edges: sync_out=4'b0011, drive async_in=4'b1100 -> rise_pulse=4'b1100 and fall_pulse=4'b0011 in the same cycle, any_change=1 for one cycle.
- Reset mid-operation: drive 4'b1111 and assert rst 1 edge later -> at that edge all outputs are RST_VAL with no pulses. After rst deasserts with async_in held at 4'b1111, sync_out=4'b1111 after STAGES(+FILTER_LEN) edges, with a single rise_pulse.
